// File: rtl/alu_pkg.sv
// Opcode/funct encodings and flag bit positions shared by the MIPS ALU.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_OVF  = 0;

endpackage

// File: rtl/mips_alu_if.sv
// Execute-stage bundle: instruction and register operands in, result and flags out.
interface mips_alu_if;
  logic [31:0] instruction;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (output instruction, output regA, output regB, input result, input flags);
  modport slave  (input instruction, input regA, input regB, output result, output flags);
endinterface

// File: rtl/alu_core.sv
// Combinational decode, operand select and compute for the MIPS ALU.
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic [31:0] reg_a,
  input  logic [31:0] reg_b,
  output logic [31:0] next_result,
  output logic [2:0]  next_flags
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, shamt;
  logic [31:0] a, b, simm, zimm;
  logic [31:0] sum_ab, diff_ab, sum_ai;

  assign op    = instruction[31:26];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign shamt = instruction[10:6];
  assign funct = instruction[5:0];
  assign simm  = {{16{instruction[15]}}, instruction[15:0]};
  assign zimm  = {16'd0, instruction[15:0]};

  // Only two registers exist: address 0 is regA, any other address is regB.
  assign a = (rs == 5'd0) ? reg_a : reg_b;
  assign b = (rt == 5'd0) ? reg_a : reg_b;

  assign sum_ab  = a + b;
  assign diff_ab = a - b;
  assign sum_ai  = a + simm;

  always_comb begin
    next_result = '0;
    next_flags  = '0;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD: begin
            next_result          = sum_ab;
            next_flags[FLAG_OVF] = (a[31] == b[31]) && (sum_ab[31] != a[31]);
          end
          FN_ADDU: next_result = sum_ab;
          FN_SUB: begin
            next_result          = diff_ab;
            next_flags[FLAG_OVF] = (a[31] != b[31]) && (diff_ab[31] != a[31]);
          end
          FN_SUBU: next_result = diff_ab;
          FN_AND:  next_result = a & b;
          FN_OR:   next_result = a | b;
          FN_XOR:  next_result = a ^ b;
          FN_NOR:  next_result = ~(a | b);
          FN_SLT: begin
            next_flags[FLAG_NEG] = $signed(a) < $signed(b);
            next_result          = {31'd0, next_flags[FLAG_NEG]};
          end
          FN_SLTU: begin
            next_flags[FLAG_NEG] = a < b;
            next_result          = {31'd0, next_flags[FLAG_NEG]};
          end
          FN_SLL:  next_result = b << shamt;
          FN_SRL:  next_result = b >> shamt;
          FN_SRA:  next_result = $unsigned($signed(b) >>> shamt);
          FN_SLLV: next_result = b << a[4:0];
          FN_SRLV: next_result = b >> a[4:0];
          FN_SRAV: next_result = $unsigned($signed(b) >>> a[4:0]);
          default: ;
        endcase
      end
      OP_ADDI: begin
        next_result          = sum_ai;
        next_flags[FLAG_OVF] = (a[31] == simm[31]) && (sum_ai[31] != a[31]);
      end
      OP_ADDIU, OP_LW, OP_SW: next_result = sum_ai;
      OP_ANDI: next_result = a & zimm;
      OP_ORI:  next_result = a | zimm;
      OP_XORI: next_result = a ^ zimm;
      OP_SLTI: begin
        next_flags[FLAG_NEG] = $signed(a) < $signed(simm);
        next_result          = {31'd0, next_flags[FLAG_NEG]};
      end
      OP_SLTIU: begin
        next_flags[FLAG_NEG] = a < simm;
        next_result          = {31'd0, next_flags[FLAG_NEG]};
      end
      OP_BEQ, OP_BNE: begin
        next_result           = diff_ab;
        next_flags[FLAG_ZERO] = (a == b);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// MIPS execute-stage ALU: combinational core followed by an async-reset output register.
module mips_alu (
  input logic       clk,
  input logic       rst,
  mips_alu_if.slave bus
);

  logic [31:0] next_result, result_q;
  logic [2:0]  next_flags, flags_q;

  alu_core u_core (
    .instruction (bus.instruction),
    .reg_a       (bus.regA),
    .reg_b       (bus.regB),
    .next_result (next_result),
    .next_flags  (next_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= next_result;
      flags_q  <= next_flags;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: driver queues expectations, monitor checks each captured edge.
module tb_mips_alu;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mips_alu_if bus ();

  mips_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_r_q[$];
  logic [2:0]  exp_f_q[$];
  string       exp_n_q[$];

  task automatic compare(input string name, input logic [31:0] got_r, input logic [2:0] got_f,
                         input logic [31:0] want_r, input logic [2:0] want_f);
    n_cmp++;
    if (got_r !== want_r || got_f !== want_f) begin
      n_fail++;
      $display("FAIL %s: got result=%h flags=%b, want result=%h flags=%b",
               name, got_r, got_f, want_r, want_f);
    end
  endtask

  task automatic issue(input string name, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want_r, input logic [2:0] want_f);
    @(negedge clk);
    bus.instruction = instr;
    bus.regA        = a;
    bus.regB        = b;
    exp_r_q.push_back(want_r);
    exp_f_q.push_back(want_f);
    exp_n_q.push_back(name);
  endtask

  // Monitor: every rising edge captures, so pop one expectation per edge while one is pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_r_q.size() > 0) begin
        compare(exp_n_q.pop_front(), bus.result, bus.flags, exp_r_q.pop_front(),
                exp_f_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.instruction = '0;
    bus.regA        = '0;
    bus.regB        = '0;
    #1 rst = 1'b1;
    #2 compare("reset_init", bus.result, bus.flags, 32'h0, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    issue("addu",      32'h00010021, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 3'b000);
    issue("addiu",     32'h24017FFF, 32'h7FFFFFFF, 32'h0,        32'h80007FFE, 3'b000);
    issue("addi_ovf",  32'h20017FFF, 32'h7FFFFFFF, 32'h0,        32'h80007FFE, 3'b001);
    issue("add_ovf",   32'h00010020, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b001);
    issue("sub_ovf",   32'h00010022, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b001);
    issue("subu",      32'h00010023, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b000);
    issue("beq_eq",    32'h10010000, 32'h00000005, 32'h00000005, 32'h00000000, 3'b100);
    issue("bne_ne",    32'h14010000, 32'h00000005, 32'h00000003, 32'h00000002, 3'b000);
    issue("slt",       32'h0001002A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 3'b010);
    issue("sltu",      32'h0001002B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b000);
    issue("sra4",      32'h00010103, 32'h0,        32'h80000000, 32'hF8000000, 3'b000);
    issue("srl4",      32'h00010102, 32'h0,        32'h80000000, 32'h08000000, 3'b000);
    issue("sllv1",     32'h00010004, 32'h00000001, 32'h80000000, 32'h00000000, 3'b000);
    issue("sll31",     32'h000107C0, 32'h0,        32'h00000001, 32'h80000000, 3'b000);
    issue("nor",       32'h00010027, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 3'b000);
    issue("andi_zext", 32'h30018000, 32'hFFFFFFFF, 32'h0,        32'h00008000, 3'b000);
    issue("slti",      32'h2801FFFF, 32'hFFFFFFFE, 32'h0,        32'h00000001, 3'b010);
    issue("sltiu",     32'h2C01FFFF, 32'hFFFFFFFE, 32'h0,        32'h00000001, 3'b010);
    issue("lw_addr",   32'h8C01FFFC, 32'h00000100, 32'h0,        32'h000000FC, 3'b000);
    issue("rs1_sel_b", 32'h00210021, 32'h00000001, 32'h00000005, 32'h0000000A, 3'b000);
    issue("bad_op",    32'h3C01FFFF, 32'h12345678, 32'h1,        32'h00000000, 3'b000);
    issue("bad_funct", 32'h00010001, 32'h12345678, 32'h1,        32'h00000000, 3'b000);
    issue("add_pre",   32'h00010020, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b001);

    // Mid-cycle async reset must clear outputs immediately and hold across an edge.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 compare("rst_async", bus.result, bus.flags, 32'h0, 3'b000);
    @(posedge clk);
    #1 compare("rst_hold", bus.result, bus.flags, 32'h0, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    exp_r_q.push_back(32'h80000000);
    exp_f_q.push_back(3'b001);
    exp_n_q.push_back("rst_release");

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_r_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_r_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
